// File: rtl/imem_loader_pkg.sv
// -----------------------------------------------------------------------------
// imem_loader_pkg
// Shared types and constants for the instruction-memory loader.
//   state_t      : loader FSM state encoding
//   HDR_WIDTH    : width of the little-endian word-count header
//   word_addr()  : byte address of instruction word <idx> above <base>
//   stream_open(): states in which the loader accepts stream bytes
// -----------------------------------------------------------------------------
package imem_loader_pkg;

    localparam int HDR_WIDTH = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HDR_LO = 3'd1,
        ST_HDR_HI = 3'd2,
        ST_DATA   = 3'd3,
        ST_WRITE  = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERR    = 3'd6
    } state_t;

    // Word index scaled to a byte offset (x4) and added to the base address.
    function automatic logic [31:0] word_addr(input logic [31:0]          base,
                                              input logic [HDR_WIDTH-1:0] idx);
        return base + {{(30-HDR_WIDTH){1'b0}}, idx, 2'b00};
    endfunction

    // byte_ready is high exactly in the states that consume stream bytes.
    function automatic logic stream_open(input state_t s);
        return (s == ST_HDR_LO) || (s == ST_HDR_HI) || (s == ST_DATA);
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// -----------------------------------------------------------------------------
// imem_loader_if
// Bundles the byte stream handshake and the instruction-memory write bus.
//   byte_valid / byte_data / byte_ready : valid-ready byte stream into loader
//   imem_we / imem_addr / imem_wdata    : single-cycle write strobe to IMEM
// Modports:
//   master : environment side (drives the stream, observes the write bus)
//   slave  : loader side (consumes the stream, drives the write bus)
// -----------------------------------------------------------------------------
interface imem_loader_if;

    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;

    modport master (
        output byte_valid,
        output byte_data,
        input  byte_ready,
        input  imem_we,
        input  imem_addr,
        input  imem_wdata
    );

    modport slave (
        input  byte_valid,
        input  byte_data,
        output byte_ready,
        output imem_we,
        output imem_addr,
        output imem_wdata
    );

endinterface

// File: rtl/imem_byte_assembler.sv
// -----------------------------------------------------------------------------
// imem_byte_assembler
// Packs four consecutive accepted bytes into a little-endian 32-bit word.
// Ports:
//   clk, rst   : clock, asynchronous active-low reset
//   clear      : drop any partial word (new load starting)
//   byte_en    : byte_in is accepted this cycle
//   byte_in    : stream byte
//   word       : word including the byte being accepted this cycle
//   word_ready : this cycle's accepted byte completes a word
// -----------------------------------------------------------------------------
module imem_byte_assembler (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        byte_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_ready
);

    logic [1:0]  byte_cnt_reg;
    logic [31:0] shift_reg;
    logic [31:0] shift_next;

    // New bytes enter at the top and drift down, so after four shifts the
    // first byte of the word sits in bits 7:0.
    assign shift_next = {byte_in, shift_reg[31:8]};
    assign word       = shift_next;
    assign word_ready = byte_en && (byte_cnt_reg == 2'd3);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byte_cnt_reg <= 2'd0;
            shift_reg    <= 32'd0;
        end else if (clear) begin
            byte_cnt_reg <= 2'd0;
            shift_reg    <= 32'd0;
        end else if (byte_en) begin
            // Counter wraps naturally from 3 to 0 at the end of each word.
            byte_cnt_reg <= byte_cnt_reg + 2'd1;
            shift_reg    <= shift_next;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
// Receives a byte stream (16-bit LE word count N, then 4*N bytes of LE words),
// writes each word into instruction memory and holds the core in reset until
// the full image has been written.
// Parameters:
//   DEPTH     : instruction-memory capacity in 32-bit words
//   BASE_ADDR : byte address of the first word written
// Ports:
//   clk, rst  : clock, asynchronous active-low reset
//   start     : one-cycle pulse that begins a load (from IDLE, DONE or ERR)
//   bus       : byte stream in + IMEM write bus out (imem_loader_if.slave)
//   core_rst  : active-high core reset, low only once the load completed
//   done      : load completed successfully
//   error     : header rejected (N == 0 or N > DEPTH)
// -----------------------------------------------------------------------------
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int          DEPTH     = 64,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    imem_loader_if.slave bus,
    output logic         core_rst,
    output logic         done,
    output logic         error
);

    localparam logic [31:0] DEPTH_W = 32'(DEPTH);

    state_t               state_reg;
    state_t               state_next;
    logic [HDR_WIDTH-1:0] count_reg;
    logic [HDR_WIDTH-1:0] index_reg;
    logic [HDR_WIDTH-1:0] index_next;
    logic [HDR_WIDTH-1:0] hdr_count;
    logic                 byte_ready_reg;
    logic                 imem_we_reg;
    logic [31:0]          imem_addr_reg;
    logic [31:0]          imem_wdata_reg;
    logic                 core_rst_reg;
    logic                 done_reg;
    logic                 error_reg;

    logic                 accept;
    logic                 load_start;
    logic                 asm_en;
    logic                 hdr_bad;
    logic [31:0]          asm_word;
    logic                 word_ready;

    // byte_ready is registered, so a handshake only ever happens in a state
    // that is allowed to consume bytes.
    assign accept     = bus.byte_valid && byte_ready_reg;
    assign load_start = start && ((state_reg == ST_IDLE) ||
                                  (state_reg == ST_DONE) ||
                                  (state_reg == ST_ERR));
    assign asm_en     = accept && (state_reg == ST_DATA);

    // Full header as it will look once the high byte is captured.
    assign hdr_count  = {bus.byte_data, count_reg[7:0]};
    assign hdr_bad    = (hdr_count == '0) ||
                        ({{(32-HDR_WIDTH){1'b0}}, hdr_count} > DEPTH_W);
    assign index_next = index_reg + 1'b1;

    imem_byte_assembler u_assembler (
        .clk        (clk),
        .rst        (rst),
        .clear      (load_start),
        .byte_en    (asm_en),
        .byte_in    (bus.byte_data),
        .word       (asm_word),
        .word_ready (word_ready)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (start) state_next = ST_HDR_LO;
            ST_HDR_LO: if (accept) state_next = ST_HDR_HI;
            ST_HDR_HI: if (accept) state_next = hdr_bad ? ST_ERR : ST_DATA;
            ST_DATA:   if (word_ready) state_next = ST_WRITE;
            ST_WRITE:  state_next = (index_next == count_reg) ? ST_DONE : ST_DATA;
            ST_DONE:   if (start) state_next = ST_HDR_LO;
            ST_ERR:    if (start) state_next = ST_HDR_LO;
            default:   state_next = ST_IDLE;
        endcase
    end

    // All outputs are registered from the next state so they line up with
    // the state they describe (core_rst falls on the same edge DONE begins).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= ST_IDLE;
            count_reg      <= '0;
            index_reg      <= '0;
            byte_ready_reg <= 1'b0;
            imem_we_reg    <= 1'b0;
            imem_addr_reg  <= BASE_ADDR;
            imem_wdata_reg <= 32'd0;
            core_rst_reg   <= 1'b1;
            done_reg       <= 1'b0;
            error_reg      <= 1'b0;
        end else begin
            state_reg      <= state_next;
            byte_ready_reg <= stream_open(state_next);
            imem_we_reg    <= (state_next == ST_WRITE);
            core_rst_reg   <= (state_next != ST_DONE);
            done_reg       <= (state_next == ST_DONE);
            error_reg      <= (state_next == ST_ERR);

            if (load_start) begin
                count_reg <= '0;
                index_reg <= '0;
            end

            if ((state_reg == ST_HDR_LO) && accept) begin
                count_reg[7:0] <= bus.byte_data;
            end

            if ((state_reg == ST_HDR_HI) && accept) begin
                count_reg <= hdr_count;
            end

            // Address/data are captured with the completing byte and held
            // steady through the single WRITE cycle and afterwards.
            if (word_ready) begin
                imem_wdata_reg <= asm_word;
                imem_addr_reg  <= word_addr(BASE_ADDR, index_reg);
            end

            if (state_reg == ST_WRITE) begin
                index_reg <= index_next;
            end
        end
    end

    assign bus.byte_ready = byte_ready_reg;
    assign bus.imem_we    = imem_we_reg;
    assign bus.imem_addr  = imem_addr_reg;
    assign bus.imem_wdata = imem_wdata_reg;
    assign core_rst       = core_rst_reg;
    assign done           = done_reg;
    assign error          = error_reg;

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
// Directed bench for imem_loader: a scoreboard queue holds the writes each
// load must produce; a monitor pops and compares on every imem_we.
// -----------------------------------------------------------------------------
module tb_imem_loader;

    localparam logic [31:0] BASE = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic core_rst;
    logic done;
    logic error;

    imem_loader_if bus ();

    imem_loader #(
        .DEPTH     (64),
        .BASE_ADDR (BASE)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .bus      (bus),
        .core_rst (core_rst),
        .done     (done),
        .error    (error)
    );

    always #5 clk = ~clk;

    wr_t         sb[$];
    logic [31:0] words_q[$];
    int          vectors     = 0;
    int          miscompares = 0;
    int          write_count = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Write monitor plus always-true relations between the status outputs.
    always @(negedge clk) begin
        if (rst) begin
            if (bus.imem_we === 1'b1) begin
                wr_t exp;
                write_count++;
                if (sb.size() == 0) begin
                    check("unexpected_write", bus.imem_addr, 32'hFFFF_FFFF);
                end else begin
                    exp = sb.pop_front();
                    check("write_addr", bus.imem_addr, exp.addr);
                    check("write_data", bus.imem_wdata, exp.data);
                    $display("write #%0d addr=%h data=%h", write_count, bus.imem_addr, bus.imem_wdata);
                end
            end
            check("core_rst_vs_done", {31'd0, core_rst}, {31'd0, ~done});
            check("done_error_excl", {31'd0, done & error}, 32'd0);
        end
    end

    task automatic pulse_start;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int k;
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        for (k = 0; k < 50; k++) begin
            @(negedge clk);
            if (bus.byte_ready === 1'b1) break;
        end
        if (k == 50) begin
            check("byte_accept_timeout", 32'd0, 32'd1);
        end else begin
            @(posedge clk);
        end
        #1;
        bus.byte_valid = 1'b0;
    endtask

    task automatic gap_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_word(input int idx, input logic [31:0] w, input int gap);
        sb.push_back('{addr: BASE + 32'(idx) * 32'd4, data: w});
        for (int j = 0; j < 4; j++) begin
            gap_cycles(gap);
            send_byte(w[8*j +: 8]);
        end
    endtask

    // Header then every word in words_q, with <gap> idle cycles before each byte.
    task automatic load(input int n, input int gap);
        logic [15:0] hdr;
        hdr = 16'(n);
        gap_cycles(gap);
        send_byte(hdr[7:0]);
        gap_cycles(gap);
        send_byte(hdr[15:8]);
        for (int i = 0; i < n; i++) send_word(i, words_q[i], gap);
    endtask

    // exp_flags = {done, error} required when the load terminates.
    task automatic wait_flags(input string tag, input logic [1:0] exp_flags);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done || error) break;
        end
        check(tag, {30'd0, done, error}, {30'd0, exp_flags});
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_byte_ready"}, {31'd0, bus.byte_ready}, 32'd0);
        check({tag, "_imem_we"},    {31'd0, bus.imem_we},    32'd0);
        check({tag, "_imem_addr"},  bus.imem_addr,           BASE);
        check({tag, "_imem_wdata"}, bus.imem_wdata,          32'd0);
        check({tag, "_core_rst"},   {31'd0, core_rst},       32'd1);
        check({tag, "_done"},       {31'd0, done},           32'd0);
        check({tag, "_error"},      {31'd0, error},          32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
        #1 rst = 1'b0;
        #11;
        check_reset_outputs("reset");
        @(posedge clk);
        #1 rst = 1'b1;
        gap_cycles(2);

        // Bytes offered in IDLE are not taken.
        bus.byte_valid = 1'b1;
        bus.byte_data  = 8'h5A;
        repeat (3) begin
            @(negedge clk);
            check("idle_byte_ready", {31'd0, bus.byte_ready}, 32'd0);
        end
        @(posedge clk);
        #1 bus.byte_valid = 1'b0;

        // Two-word reference image.
        words_q = '{32'h0050_0193, 32'h00A0_0513};
        pulse_start();
        load(2, 0);
        wait_flags("n2_done", 2'b10);
        check("n2_core_rst_low", {31'd0, core_rst}, 32'd0);
        check("n2_write_count", 32'(write_count), 32'd2);
        check("n2_sb_empty", 32'(sb.size()), 32'd0);

        // Bytes offered in DONE are not taken.
        bus.byte_valid = 1'b1;
        @(negedge clk);
        check("done_byte_ready", {31'd0, bus.byte_ready}, 32'd0);
        bus.byte_valid = 1'b0;

        // Restart from DONE, with a start pulse mid-word that must be ignored.
        pulse_start();
        @(negedge clk);
        check("reload_done_clr", {31'd0, done}, 32'd0);
        check("reload_core_rst", {31'd0, core_rst}, 32'd1);
        check("reload_ready", {31'd0, bus.byte_ready}, 32'd1);
        @(posedge clk);
        #1;
        send_byte(8'h01);
        send_byte(8'h00);
        sb.push_back('{addr: BASE, data: 32'hDEAD_BEEF});
        send_byte(8'hEF);
        send_byte(8'hBE);
        pulse_start();
        send_byte(8'hAD);
        send_byte(8'hDE);
        wait_flags("mid_start_done", 2'b10);
        check("mid_start_writes", 32'(write_count), 32'd3);

        // Zero-length header.
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h00);
        wait_flags("hdr_zero_err", 2'b01);
        check("hdr_zero_core_rst", {31'd0, core_rst}, 32'd1);
        bus.byte_valid = 1'b1;
        @(negedge clk);
        check("err_byte_ready", {31'd0, bus.byte_ready}, 32'd0);
        bus.byte_valid = 1'b0;
        gap_cycles(2);
        check("hdr_zero_writes", 32'(write_count), 32'd3);

        // One word beyond capacity (65 > 64).
        pulse_start();
        send_byte(8'h41);
        send_byte(8'h00);
        wait_flags("hdr_65_err", 2'b01);
        gap_cycles(2);
        check("hdr_65_writes", 32'(write_count), 32'd3);

        // Exactly full capacity: last write lands at BASE + 0xFC.
        words_q.delete();
        for (int i = 0; i < 64; i++) words_q.push_back($urandom);
        pulse_start();
        load(64, 0);
        wait_flags("n64_done", 2'b10);
        check("n64_writes", 32'(write_count), 32'd67);
        check("n64_last_addr", bus.imem_addr, BASE + 32'h0000_00FC);

        // Five idle cycles between every byte.
        words_q = '{32'h0050_0193};
        pulse_start();
        load(1, 5);
        wait_flags("gap_done", 2'b10);
        check("gap_writes", 32'(write_count), 32'd68);

        // Reset after three data bytes abandons the load.
        pulse_start();
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h93);
        send_byte(8'h01);
        send_byte(8'h50);
        #2 rst = 1'b0;
        #1;
        check_reset_outputs("abort");
        @(posedge clk);
        #1 rst = 1'b1;
        gap_cycles(6);
        check("abort_writes", 32'(write_count), 32'd68);
        check("abort_idle_ready", {31'd0, bus.byte_ready}, 32'd0);

        words_q = '{32'h0050_0193};
        pulse_start();
        load(1, 0);
        wait_flags("after_abort_done", 2'b10);
        check("after_abort_writes", 32'(write_count), 32'd69);
        check("after_abort_sb", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
